// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between four byte sources.
// One byte per grant; tracks uart_ready low/high around each byte.
module uart_tx_arbiter #(
   parameter logic [4:0] TIMEOUT = 5'd16
) (
   input  logic        clock_50M,
   input  logic        n_rst,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  ack,
   input  logic        uart_ready,
   output logic        uart_start,
   output logic [7:0]  uart_data,
   output logic        busy,
   output logic [1:0]  last_grant,
   output logic        err_timeout
);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_LOW,
      WAIT_HIGH
   } state_t;

   state_t      state, state_n;
   logic [1:0]  ptr, ptr_n;
   logic [4:0]  cnt, cnt_n;
   logic [7:0]  data_n;
   logic [1:0]  grant_n;
   logic [3:0]  ack_n;
   logic        start_n;
   logic        err_n;
   logic        found;
   logic [1:0]  sel;
   logic [1:0]  idx;

   always_ff @(posedge clock_50M or negedge n_rst) begin
      if (!n_rst) begin
         state       <= IDLE;
         ptr         <= 2'd0;
         cnt         <= 5'd0;
         uart_data   <= 8'd0;
         last_grant  <= 2'd0;
         ack         <= 4'd0;
         uart_start  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state       <= state_n;
         ptr         <= ptr_n;
         cnt         <= cnt_n;
         uart_data   <= data_n;
         last_grant  <= grant_n;
         ack         <= ack_n;
         uart_start  <= start_n;
         err_timeout <= err_n;
      end
   end

   // First requester at or after ptr, wrapping modulo 4
   always_comb begin
      found = 1'b0;
      sel   = ptr;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      cnt_n   = cnt;
      data_n  = uart_data;
      grant_n = last_grant;
      ack_n   = 4'd0;
      start_n = 1'b0;
      err_n   = 1'b0;
      unique case (state)
         IDLE: begin
            if (uart_ready && found) begin
               data_n      = req_data[{sel, 3'b000} +: 8];
               start_n     = 1'b1;
               ack_n[sel]  = 1'b1;
               grant_n     = sel;
               ptr_n       = sel + 2'd1;
               state_n     = START;
            end
         end
         START: begin
            cnt_n   = 5'd0;
            state_n = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!uart_ready) begin
               state_n = WAIT_HIGH;
            end else if (cnt == TIMEOUT - 5'd1) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 5'd1;
            end
         end
         WAIT_HIGH: begin
            if (uart_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart_tx ready stub.
// Expected values are hand-derived per scenario.
module tb_uart_tx_arbiter;

   localparam int FRAME = 20;

   logic        clock_50M = 1'b0;
   logic        n_rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        uart_ready;
   logic        uart_start;
   logic [7:0]  uart_data;
   logic        busy;
   logic [1:0]  last_grant;
   logic        err_timeout;

   int n_chk  = 0;
   int n_fail = 0;
   int overlap = 0;
   bit stuck  = 1'b0;
   int fcnt;

   uart_tx_arbiter dut (
      .clock_50M   (clock_50M),
      .n_rst       (n_rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .uart_ready  (uart_ready),
      .uart_start  (uart_start),
      .uart_data   (uart_data),
      .busy        (busy),
      .last_grant  (last_grant),
      .err_timeout (err_timeout)
   );

   always #10 clock_50M = ~clock_50M;

   // uart_tx stand-in: ready falls after start, rises FRAME cycles later
   always @(posedge clock_50M or negedge n_rst) begin
      if (!n_rst) begin
         uart_ready <= 1'b1;
         fcnt       <= 0;
      end else begin
         if (uart_start && !uart_ready) overlap <= overlap + 1;
         if (stuck) begin
            uart_ready <= 1'b1;
            fcnt       <= 0;
         end else if (uart_start) begin
            uart_ready <= 1'b0;
            fcnt       <= FRAME;
         end else if (fcnt != 0) begin
            fcnt <= fcnt - 1;
            if (fcnt == 1) uart_ready <= 1'b1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock_50M);
      #1;
   endtask

   task automatic wait_ack(input string tag);
      int i;
      for (i = 0; i < 200; i++) begin
         tick();
         if (ack != 4'd0) break;
      end
      if (i == 200) check({tag, "_ack_to"}, 0, 1);
   endtask

   task automatic wait_idle(input string tag);
      int i;
      for (i = 0; i < 200; i++) begin
         if (!busy) break;
         tick();
      end
      if (i == 200) check({tag, "_idle_to"}, 0, 1);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      #25;
      @(negedge clock_50M);
      n_rst = 1'b1;
      tick();
   endtask

   initial begin
      int n;
      n_rst    = 1'b0;
      req      = 4'd0;
      req_data = 32'd0;
      #25;
      check("rst_ack",   ack, 0);
      check("rst_start", uart_start, 0);
      check("rst_busy",  busy, 0);
      check("rst_data",  uart_data, 0);
      check("rst_grant", last_grant, 0);
      check("rst_err",   err_timeout, 0);
      @(negedge clock_50M);
      n_rst = 1'b1;
      repeat (3) tick();
      check("idle_ack",  ack, 0);
      check("idle_busy", busy, 0);

      // single request on lane 2
      req_data = 32'h00A5_0000;
      req      = 4'b0100;
      tick();
      check("one_ack",   ack, 4'b0100);
      check("one_start", uart_start, 1);
      check("one_data",  uart_data, 8'hA5);
      check("one_grant", last_grant, 2);
      check("one_busy",  busy, 1);
      req = 4'd0;
      tick();
      check("one_ack_w",   ack, 0);
      check("one_start_w", uart_start, 0);
      wait_idle("one");
      check("one_hold", uart_data, 8'hA5);

      // contention, ptr back to 0
      do_reset();
      req_data = 32'h4433_2211;
      req      = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_ack("ctn");
         check("ctn_ack",   ack, 4'b0001 << (g % 4));
         check("ctn_grant", last_grant, g % 4);
         check("ctn_data",  uart_data, 8'h11 * ((g % 4) + 1));
      end
      req = 4'd0;
      wait_idle("ctn");
      check("ctn_overlap", overlap, 0);

      // rotation: last_grant=1 leaves ptr=2
      req = 4'b0010;
      wait_ack("rot_pre");
      check("rot_pre", last_grant, 1);
      req = 4'd0;
      wait_idle("rot_pre");
      req = 4'b0011;
      wait_ack("rot0");
      check("rot_first", ack, 4'b0001);
      wait_ack("rot1");
      check("rot_second", ack, 4'b0010);
      req = 4'd0;
      wait_idle("rot");

      // timeout with ready stuck high; ptr=2 -> grant 3
      stuck = 1'b1;
      req   = 4'b1000;
      wait_ack("to");
      check("to_ack", ack, 4'b1000);
      req = 4'd0;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (err_timeout) begin
            n = i;
            break;
         end
      end
      check("to_delay", n, 17);
      check("to_busy", busy, 0);
      tick();
      check("to_pulse", err_timeout, 0);
      req = 4'b0001;
      wait_ack("to_next");
      check("to_next", ack, 4'b0001);
      req = 4'd0;
      wait_idle("to_next");
      stuck = 1'b0;

      // reset mid-byte in WAIT_HIGH; ptr=1 -> grant 2
      req = 4'b0100;
      wait_ack("mid");
      req = 4'd0;
      repeat (3) tick();
      check("mid_wh", uart_ready, 0);
      n_rst = 1'b0;
      #1;
      check("mid_busy",  busy, 0);
      check("mid_ack",   ack, 0);
      check("mid_start", uart_start, 0);
      check("mid_grant", last_grant, 0);
      @(negedge clock_50M);
      n_rst = 1'b1;
      req   = 4'b1100;
      wait_ack("mid_p");
      check("mid_ptr", last_grant, 2);
      req = 4'd0;
      wait_idle("mid_p");
      req = 4'b1000;
      wait_ack("mid_n");
      check("mid_req3", ack, 4'b1000);
      req = 4'd0;
      wait_idle("mid_n");

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
